iterative_shifter: RTL and testbench
====================================

// Module: iterative_shifter
// PURPOSE
//   Multi-cycle, parametrised successor of the MIC-1 datapath shifter. Shifts/rotates a DATA_WIDTH
//   operand by a run-time amount, at most STEP bit positions per clock, behind a start/done handshake.
//   Sits after the ALU; the MIC-1 codes map directly: SRA1 = (MODE_SRA, shamt 1), SLL8 = (MODE_SLL, shamt 8).
// PARAMETERS
//   DATA_WIDTH   32   operand/result width, >= 2
//   STEP         1    max bit positions shifted per cycle; power of two, 1..DATA_WIDTH
//   SHAMT_WIDTH  $clog2(DATA_WIDTH)  localparam, width of shift amount; not overridable
// PORTS
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous, active-low reset
//   start     in   1            request; accepted only while ready=1
//   flush     in   1            abort in-flight operation, return to IDLE
//   mode      in   3            operation select (see BEHAVIOUR)
//   shamt     in   SHAMT_WIDTH  shift amount, 0..DATA_WIDTH-1
//   data_in   in   DATA_WIDTH   operand, sampled on accepted start
//   ready     out  1            1 in IDLE
//   busy      out  1            1 in SHIFT
//   done      out  1            one-cycle pulse, result valid
//   data_out  out  DATA_WIDTH   result; held stable from done until next accepted start
// BEHAVIOUR
//   Reset (async assert, sync deassert usage): state=IDLE, ready=1, busy=0, done=0, data_out=0.
//   Modes: 000 PASS, 001 SRA (sign fill), 010 SLL (zero fill), 011 SRL (zero fill),
//          100 ROR, 101 ROL, 110/111 treated as PASS. mode/shamt/data_in latched on accept.
//   FSM IDLE -> SHIFT on start&ready (remaining<=shamt, acc<=data_in); shamt==0 or PASS goes IDLE -> DONE.
//   SHIFT: each cycle shift acc by k=min(STEP,remaining), remaining-=k; when remaining reaches 0
//          after the update, -> DONE. DONE: done=1 one cycle, data_out<=acc, -> IDLE.
//   Latency accepted-start to done: ceil(shamt/STEP)+1 cycles (shamt 0 -> 1 cycle).
//   start while busy or in DONE: ignored, no queuing. start and done never coincide in ready.
//   flush: highest priority; from SHIFT/DONE -> IDLE next cycle, no done pulse, data_out keeps old value;
//          flush with start in IDLE -> start ignored.
//   Arithmetic: rotates are modulo DATA_WIDTH; SRA of negative operand by DATA_WIDTH-1 -> all ones.
//   rst_n low mid-operation: immediate return to reset values; no done pulse afterwards.
// STRUCTURE
//   shifter_pkg: MODE_* localparams (3-bit), state encoding ST_IDLE/ST_SHIFT/ST_DONE, default widths.
//   Sub-module shift_step: combinational, shifts by 0..STEP per mode; instanced once in the datapath.
//   Top: FSM, remaining-count register (SHAMT_WIDTH), acc register, result register.
// TESTING
//   1. Reset: rst_n=0 mid-SHIFT -> ready=1, busy=0, done=0, data_out=0 immediately (no clk edge needed).
//   2. Legacy SRA1: data_in=32'h88888888, SRA, shamt 1, STEP=1 -> done after 2 cycles, data_out=32'hC4444444.
//   3. Legacy SLL8: data_in=32'h88888888, SLL, shamt 8, STEP=1 -> done after 9 cycles, data_out=32'h88888800;
//      repeat with STEP=4 -> done after 3 cycles, same result.
//   4. Rotates/SRL: ROR 32'h0000_0001 by 1 -> 32'h8000_0000; ROL 32'h8000_0001 by 4 -> 32'h0000_0018;
//      SRL 32'h8000_0000 by 31 -> 32'h0000_0001; shamt 0 -> done after 1 cycle, data_out=data_in.
//   5. Handshake: start pulses while busy -> ignored, result equals first operation only;
//      flush on 3rd SHIFT cycle -> no done, ready=1 next cycle, data_out unchanged from prior result.
//   6. Randomised sweep (1000 ops, DATA_WIDTH 8/32, STEP 1/2/8) against behavioural model, checking
//      latency = ceil(shamt/STEP)+1 and data_out stability between done pulses.

Source files
------------

// File: rtl/iterative_shifter_pkg.sv
// rtl/iterative_shifter_pkg.sv - shared modes, states and defaults for iterative_shifter
// Purpose : operation codes, FSM state encoding, default widths and a mode
//           classification helper shared by the shifter, its step and its bus.
// Ports   : none (package).
package iterative_shifter_pkg;

  localparam int MODE_WIDTH         = 3;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_STEP       = 1;

  localparam logic [MODE_WIDTH-1:0] MODE_PASS = 3'b000;
  localparam logic [MODE_WIDTH-1:0] MODE_SRA  = 3'b001;
  localparam logic [MODE_WIDTH-1:0] MODE_SLL  = 3'b010;
  localparam logic [MODE_WIDTH-1:0] MODE_SRL  = 3'b011;
  localparam logic [MODE_WIDTH-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_WIDTH-1:0] MODE_ROL  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Codes 110/111 behave as PASS, so anything that is not a real shift is a pass.
  function automatic logic is_pass(input logic [MODE_WIDTH-1:0] mode);
    return !(mode inside {MODE_SRA, MODE_SLL, MODE_SRL, MODE_ROR, MODE_ROL});
  endfunction

endpackage

// File: rtl/iterative_shifter_if.sv
// rtl/iterative_shifter_if.sv - start/done request bundle for iterative_shifter
// Purpose : groups the request (start, flush, mode, shamt, data_in) and the
//           response (ready, busy, done, data_out) of the shifter.
// Ports   : master drives the request and observes the response,
//           slave (the shifter) does the opposite.
interface iterative_shifter_if
  import iterative_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  logic                   start;
  logic                   flush;
  logic [MODE_WIDTH-1:0]  mode;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  data_out;

  modport master (
    output start, flush, mode, shamt, data_in,
    input  ready, busy, done, data_out
  );

  modport slave (
    input  start, flush, mode, shamt, data_in,
    output ready, busy, done, data_out
  );

endinterface

// File: rtl/iterative_shifter_shift_step.sv
// rtl/iterative_shifter_shift_step.sv - combinational single-step shifter
// Purpose : shifts/rotates din by k positions according to mode; the caller
//           keeps k within 0..STEP so this stays a narrow barrel stage.
// Ports   : mode (operation), din (operand), k (positions), dout (result).
module shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [MODE_WIDTH-1:0]           mode,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic [$clog2(DATA_WIDTH)-1:0]   k,
  output logic [DATA_WIDTH-1:0]           dout
);

  logic [2*DATA_WIDTH-1:0] dbl;
  logic [2*DATA_WIDTH-1:0] rot;

  always_comb begin
    // Rotates shift a doubled copy so wrapped bits fall into the kept half.
    dbl  = {din, din};
    rot  = '0;
    dout = din;
    case (mode)
      MODE_PASS: dout = din;
      MODE_SRA:  dout = $signed(din) >>> k;
      MODE_SLL:  dout = din << k;
      MODE_SRL:  dout = din >> k;
      MODE_ROR: begin
        rot  = dbl >> k;
        dout = rot[DATA_WIDTH-1:0];
      end
      MODE_ROL: begin
        rot  = dbl << k;
        dout = rot[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default:   dout = din;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - multi-cycle shifter, up to STEP positions per clock
// Purpose : accepts an operand on start, shifts it over several cycles and
//           reports the result with a one-cycle done pulse.
// Ports   : clk, rst_n (async active-low), bus (slave side of
//           iterative_shifter_if: start/flush/mode/shamt/data_in in,
//           ready/busy/done/data_out out).
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int STEP       = DEFAULT_STEP
) (
  input logic                clk,
  input logic                rst_n,
  iterative_shifter_if.slave bus
);

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  state_t                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] remaining_q;
  logic [SHAMT_WIDTH-1:0] k;
  logic [MODE_WIDTH-1:0]  mode_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]  step_out;
  logic [DATA_WIDTH-1:0]  result_q;
  logic                   accept;
  logic                   advance;
  logic                   retire;
  logic                   done_w;

  // Remaining never exceeds DATA_WIDTH-1, so when STEP == DATA_WIDTH the
  // truncated STEP branch is never taken.
  always_comb begin
    k = remaining_q;
    if (int'(remaining_q) >= STEP) k = SHAMT_WIDTH'(STEP);
  end

  shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .mode (mode_q),
    .din  (acc_q),
    .k    (k),
    .dout (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // flush wins over a simultaneous start
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          state_d = (bus.shamt == '0 || is_pass(bus.mode)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          advance = 1'b1;
          if (remaining_q == k) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        retire  = !bus.flush;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      mode_q      <= MODE_PASS;
      acc_q       <= '0;
      result_q    <= '0;
    end else begin
      if (accept) begin
        remaining_q <= bus.shamt;
        mode_q      <= bus.mode;
        acc_q       <= bus.data_in;
      end else if (advance) begin
        remaining_q <= remaining_q - k;
        acc_q       <= step_out;
      end
      if (retire) result_q <= acc_q;
    end
  end

  // The finished accumulator is shown directly while done is high so the
  // result is valid in the pulse cycle; a flush in DONE suppresses both.
  assign done_w       = (state_q == ST_DONE) && !bus.flush;
  assign bus.done     = done_w;
  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.data_out = done_w ? acc_q : result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// tb/tb_iterative_shifter.sv - scoreboard bench for iterative_shifter over several widths/steps
module tb_iterative_shifter;
  import iterative_shifter_pkg::*;

  localparam int NI = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] flush_v = '0;
  logic [2:0]    mode_v = 3'b000;
  logic [4:0]    shamt_v = '0;
  logic [31:0]   data_v = '0;
  logic [NI-1:0] ready_v, busy_v, done_v;
  logic [31:0]   dout_a [NI];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int          inst;
    logic [31:0] value;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_res [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = (g >= 4) ? 8 : 32;
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : (g == 3) ? 8 : (g == 4) ? 1 : 8;
    localparam int SW = $clog2(DW);
    iterative_shifter_if #(.DATA_WIDTH(DW)) bus_i ();
    assign bus_i.start   = start_v[g];
    assign bus_i.flush   = flush_v[g];
    assign bus_i.mode    = mode_v;
    assign bus_i.shamt   = shamt_v[SW-1:0];
    assign bus_i.data_in = data_v[DW-1:0];
    iterative_shifter #(.DATA_WIDTH(DW), .STEP(ST)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
    );
    assign ready_v[g] = bus_i.ready;
    assign busy_v[g]  = bus_i.busy;
    assign done_v[g]  = bus_i.done;
    assign dout_a[g]  = 32'(bus_i.data_out);
  end

  function automatic int dw_of(input int g);
    return (g >= 4) ? 8 : 32;
  endfunction

  function automatic int step_of(input int g);
    case (g)
      0: return 1;
      1: return 4;
      2: return 2;
      3: return 8;
      4: return 1;
      default: return 8;
    endcase
  endfunction

  // Bit-level reference: each result bit is looked up from its source position.
  function automatic logic [31:0] ref_model(input int dw, input logic [2:0] m, input int s, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < dw; i++) begin
      case (m)
        3'b001: begin
          if (i + s < dw) r[i] = d[i+s];
          else            r[i] = d[dw-1];
        end
        3'b010: begin
          if (i >= s) r[i] = d[i-s];
        end
        3'b011: begin
          if (i + s < dw) r[i] = d[i+s];
        end
        3'b100: r[i] = d[(i + s) % dw];
        3'b101: r[i] = d[(i - s + dw) % dw];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] m, input int s, input int step);
    if (m == 3'b000 || m == 3'b110 || m == 3'b111 || s == 0) return 1;
    return (s + step - 1) / step + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: pops an expectation for every done pulse, and between pulses
  // requires data_out to hold the last reported result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      for (int g = 0; g < NI; g++) last_res[g] = '0;
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (done_v[g]) begin
          if (exp_q.size() == 0 || exp_q[0].inst != g) begin
            check($sformatf("unexpected_done[%0d]", g), 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("result[%0d]", g), dout_a[g], e.value);
            check($sformatf("latency[%0d]", g), 32'(cyc - e.issue), 32'(e.lat));
            last_res[g] = e.value;
          end
        end else begin
          check($sformatf("hold[%0d]", g), dout_a[g], last_res[g]);
        end
      end
    end
  end

  task automatic issue(input int g, input logic [2:0] m, input int s, input logic [31:0] d,
                       input logic [31:0] ev, input int lat, input bit push);
    int n;
    exp_t e;
    @(posedge clk); #1;
    n = 0;
    while (!ready_v[g] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_v[g]) check($sformatf("ready_timeout[%0d]", g), 32'd0, 32'd1);
    mode_v     = m;
    shamt_v    = 5'(s);
    data_v     = d;
    start_v[g] = 1'b1;
    if (push) begin
      e.inst  = g;
      e.value = ev;
      e.issue = cyc;
      e.lat   = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input int g, input logic [2:0] m, input int s, input logic [31:0] d,
                     input logic [31:0] ev, input int lat);
    issue(g, m, s, d, ev, lat, 1'b1);
    wait_done();
  endtask

  initial begin
    int g, dw, s;
    logic [2:0]  m;
    logic [31:0] d, mask;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_ready[%0d]", i), 32'(ready_v[i]), 32'd1);
      check($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst_done[%0d]", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst_dout[%0d]", i), dout_a[i], 32'd0);
    end

    // Legacy MIC-1 codes and boundary shifts
    run(0, MODE_SRA, 1, 32'h8888_8888, 32'hC444_4444, 2);
    run(0, MODE_SLL, 8, 32'h8888_8888, 32'h8888_8800, 9);
    run(1, MODE_SLL, 8, 32'h8888_8888, 32'h8888_8800, 3);
    run(3, MODE_SLL, 8, 32'h8888_8888, 32'h8888_8800, 2);
    run(0, MODE_ROR, 1, 32'h0000_0001, 32'h8000_0000, 2);
    run(0, MODE_ROL, 4, 32'h8000_0001, 32'h0000_0018, 5);
    run(0, MODE_SRL, 31, 32'h8000_0000, 32'h0000_0001, 32);
    run(0, MODE_SRA, 31, 32'h8000_1234, 32'hFFFF_FFFF, 32);
    run(0, MODE_SLL, 0, 32'h1234_5678, 32'h1234_5678, 1);
    run(2, MODE_PASS, 5, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    run(5, MODE_ROL, 7, 32'h0000_0081, 32'h0000_00C0, 2);

    // start pulses while busy are ignored
    issue(0, MODE_SLL, 8, 32'h8888_8888, 32'h8888_8800, 9, 1'b1);
    check("busy_during_shift", 32'(busy_v[0]), 32'd1);
    mode_v = MODE_ROR; shamt_v = 5'd3; data_v = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      start_v[0] = 1'b1;
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    wait_done();
    repeat (12) @(posedge clk);

    // flush on the third SHIFT cycle: no done, idle next cycle, old result kept
    issue(0, MODE_SLL, 10, 32'h0000_00FF, 32'h0, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_v[0] = 1'b1;
    @(posedge clk); #1;
    flush_v[0] = 1'b0;
    check("flush_ready", 32'(ready_v[0]), 32'd1);
    check("flush_busy", 32'(busy_v[0]), 32'd0);
    check("flush_dout", dout_a[0], 32'h8888_8800);
    repeat (15) @(posedge clk);

    // flush together with start in IDLE: start ignored
    @(posedge clk); #1;
    mode_v = MODE_SRL; shamt_v = 5'd2; data_v = 32'h0000_0F00;
    flush_v[1] = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    flush_v[1] = 1'b0;
    start_v[1] = 1'b0;
    check("flush_start_ready", 32'(ready_v[1]), 32'd1);
    repeat (5) @(posedge clk);

    // asynchronous reset in the middle of a shift
    issue(0, MODE_SLL, 20, 32'h0000_0001, 32'h0010_0000, 21, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_busy", 32'(busy_v[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_v[0]), 32'd1);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_done", 32'(done_v[0]), 32'd0);
    check("midrst_dout", dout_a[0], 32'd0);
    check("midrst_dout_g1", dout_a[1], 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);

    // randomised sweep against the reference model
    for (int n = 0; n < 1000; n++) begin
      g    = $urandom_range(0, NI - 1);
      dw   = dw_of(g);
      mask = (dw == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      m    = 3'($urandom_range(0, 7));
      s    = $urandom_range(0, dw - 1);
      d    = $urandom & mask;
      run(g, m, s, d, ref_model(dw, m, s, d), lat_of(m, s, step_of(g)));
    end
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
